// File: rtl/core_pkg.sv
// core_pkg: shared phase constants, NOP encoding, fetch FSM states and next-PC helper
package core_pkg;
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD} fetch_state_e;
  function automatic logic [31:0] next_pc(logic [31:0] pc, logic taken, logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: core-side control and instruction-memory signals of the fetch stage
interface fetch_unit_if #(parameter int ADDR_W = 14);
  logic [2:0]        state;
  logic              pc_we;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr_raw;
  logic [31:0]       pc;
  logic              fetch_done;
  logic              misalign_err;
  modport master (
    output state, pc_we, branch_taken, branch_target, imem_valid, imem_rdata,
    input  imem_req, imem_addr, instr_raw, pc, fetch_done, misalign_err
  );
  modport slave (
    input  state, pc_we, branch_taken, branch_target, imem_valid, imem_rdata,
    output imem_req, imem_addr, instr_raw, pc, fetch_done, misalign_err
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: PC register, next-PC mux, pending redirect buffer and misalign check (FETCH_MISALIGN_TRAP_EN)
module pc_reg
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we_i,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  input  logic        busy_i,
  input  logic        fetch_done_i,
  output logic [31:0] pc_o,
  output logic        misalign_err_o
);
  logic [31:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, use_tgt;
  logic        pend_q, pend_d, pend_tk_q, pend_tk_d, err_q, err_d;
  logic        direct, capture, apply, use_tk;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        bad;
`endif
  // pick the update source (live pulse beats a buffered one) and form the next PC
  always_comb begin
    direct     = pc_we_i && !busy_i;
    capture    = pc_we_i && busy_i;
    apply      = direct || (pend_q && fetch_done_i);
    use_tk     = direct ? taken_i : pend_tk_q;
    use_tgt    = direct ? target_i : pend_tgt_q;
    pend_d     = capture ? 1'b1 : (apply ? 1'b0 : pend_q);
    pend_tk_d  = capture ? taken_i : pend_tk_q;
    pend_tgt_d = capture ? target_i : pend_tgt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    bad        = apply && use_tk && (use_tgt[1:0] != 2'b00);
    pc_d       = (apply && !bad) ? next_pc(pc_q, use_tk, use_tgt) : pc_q;
    err_d      = err_q || bad;
`else
    pc_d       = apply ? next_pc(pc_q, use_tk, use_tgt & ~32'd3) : pc_q;
    err_d      = 1'b0;
`endif
  end
  // PC, pending redirect and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tk_q  <= 1'b0;
      pend_tgt_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tk_q  <= pend_tk_d;
      pend_tgt_q <= pend_tgt_d;
      err_q      <= err_d;
    end
  end
  assign pc_o           = pc_q;
  assign misalign_err_o = err_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: one instruction fetch per FETCH phase; FETCH_MISALIGN_TRAP_EN traps misaligned redirects
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input logic       clk,
  input logic       rst,
  fetch_unit_if.slave bus
);
  fetch_state_e fsm_q, fsm_d;
  logic [31:0]  instr_q, instr_d, pc;
  logic         done_q, done_d, err, busy;
  assign busy = (fsm_q == F_REQ) || (fsm_q == F_WAIT);
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst),
    .pc_we_i(bus.pc_we), .taken_i(bus.branch_taken), .target_i(bus.branch_target),
    .busy_i(busy), .fetch_done_i(done_q),
    .pc_o(pc), .misalign_err_o(err)
  );
  // fetch sequencing; HOLD blocks a second fetch until the core leaves FETCH, err halts fetching
  always_comb begin
    fsm_d   = fsm_q;
    instr_d = instr_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      F_IDLE: fsm_d = (bus.state == ST_FETCH && !err) ? F_REQ : F_IDLE;
      F_REQ:  fsm_d = F_WAIT;
      F_WAIT: begin
        fsm_d   = bus.imem_valid ? F_HOLD : F_WAIT;
        instr_d = bus.imem_valid ? bus.imem_rdata : instr_q;
        done_d  = bus.imem_valid;
      end
      F_HOLD: fsm_d = (bus.state != ST_FETCH) ? F_IDLE : F_HOLD;
      default: fsm_d = F_IDLE;
    endcase
  end
  // state, latched instruction and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= F_IDLE;
      instr_q <= NOP_INSTR;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      instr_q <= instr_d;
      done_q  <= done_d;
    end
  end
  assign bus.imem_req     = (fsm_q == F_REQ);
  assign bus.imem_addr    = pc[ADDR_W+1:2];
  assign bus.instr_raw    = instr_q;
  assign bus.pc           = pc;
  assign bus.fetch_done   = done_q;
  assign bus.misalign_err = err;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with randomized memory latency and redirects
module tb_fetch_unit;
  import core_pkg::*;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int force_lat = 1;
  logic [31:0] m_pc = 32'h0;
  logic m_err = 1'b0;
  exp_t exp_q[$];
  logic [13:0] addr_q[$];
  fetch_unit_if #(.ADDR_W(14)) fu();
  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(14)) dut (.clk(clk), .rst(rst), .bus(fu.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [13:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  function automatic logic [31:0] model_next(logic [31:0] pc, logic tk, logic [31:0] tg);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (tk && tg[1:0] != 2'b00) return pc;
    return tk ? tg : pc + 32'd4;
`else
    return tk ? {tg[31:2], 2'b00} : pc + 32'd4;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // memory: answers each request after force_lat cycles
  initial begin
    fu.imem_valid = 1'b0;
    fu.imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (fu.imem_req) begin
        automatic int l = force_lat;
        automatic logic [13:0] a = fu.imem_addr;
        repeat (l) @(posedge clk);
        #1 fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(a);
        @(posedge clk);
        #1 fu.imem_valid = 1'b0; fu.imem_rdata = $urandom;
      end
    end
  end

  // monitor: compares every request address and every delivered instruction with the queues
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (fu.imem_req) begin
          total++;
          if (addr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_req addr=%h", fu.imem_addr);
          end else begin
            automatic logic [13:0] ea = addr_q.pop_front();
            if (fu.imem_addr !== ea) begin
              bad++;
              $display("FAIL imem_addr act=%h exp=%h", fu.imem_addr, ea);
            end
          end
        end
        if (fu.fetch_done) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_fetch_done pc=%h instr=%h", fu.pc, fu.instr_raw);
          end else begin
            automatic exp_t e = exp_q.pop_front();
            chk("done_pc", fu.pc, e.pc);
            chk("done_instr", fu.instr_raw, e.ins);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    fu.state = ST_DECODE;
    fu.pc_we = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pc = 32'h0;
    m_err = 1'b0;
    chk("rst_pc", fu.pc, 32'h0);
    chk("rst_instr", fu.instr_raw, NOP_INSTR);
    chk("rst_req", 32'(fu.imem_req), 32'd0);
    chk("rst_done", 32'(fu.fetch_done), 32'd0);
    chk("rst_addr", 32'(fu.imem_addr), 32'd0);
    chk("rst_err", 32'(fu.misalign_err), 32'd0);
  endtask

  // mode 0: plain fetch; 1: pc_we at request; 2: pc_we with fetch_done; 3: both (live one wins)
  task automatic fetch_cycle(int lat, int mode, logic tk, logic [31:0] tg);
    int n = 0;
    bit got = 0;
    force_lat = lat;
    exp_q.push_back('{pc: m_pc, ins: mem_word(m_pc[15:2])});
    addr_q.push_back(m_pc[15:2]);
    fu.state = ST_FETCH;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      fu.pc_we = 1'b0;
      if ((mode == 1 || mode == 3) && fu.imem_req) begin
        fu.pc_we = 1'b1;
        fu.branch_taken = tk;
        fu.branch_target = tg;
      end
      if (fu.fetch_done) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout cycles=%0d limit=40", n);
    end else chk("fetch_latency", n, 2 + lat);
    if (mode == 2 || mode == 3) begin
      fu.pc_we = 1'b1;
      fu.branch_taken = (mode == 2) ? tk : 1'b0;
      fu.branch_target = tg;
    end
    fu.state = ST_DECODE;
    @(posedge clk); #1;
    fu.pc_we = 1'b0;
    if (mode == 1 || mode == 2) m_pc = model_next(m_pc, tk, tg);
    if (mode == 3) m_pc = m_pc + 32'd4;
    if (mode != 0) chk("pc_after_fetch", fu.pc, m_pc);
  endtask

  task automatic retire(logic tk, logic [31:0] tg);
    fu.state = ST_WRITE;
    fu.pc_we = 1'b1;
    fu.branch_taken = tk;
    fu.branch_target = tg;
    @(posedge clk); #1;
    fu.pc_we = 1'b0;
    fu.state = ST_DECODE;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (tk && tg[1:0] != 2'b00) m_err = 1'b1;
`endif
    m_pc = model_next(m_pc, tk, tg);
    chk("retire_pc", fu.pc, m_pc);
    chk("retire_err", 32'(fu.misalign_err), 32'(m_err));
  endtask

  initial begin
    fu.state = ST_DECODE;
    fu.pc_we = 1'b0;
    fu.branch_taken = 1'b0;
    fu.branch_target = 32'h0;
    do_reset();
    fetch_cycle(1, 0, 1'b0, 32'h0);
    retire(1'b0, 32'h0);
    retire(1'b1, 32'h0000_0200);
    fetch_cycle(5, 0, 1'b0, 32'h0);
    retire(1'b1, 32'h0000_0FFC);
    fetch_cycle(2, 0, 1'b0, 32'h0);
    retire(1'b0, 32'h0);
    chk("seq_pc", fu.pc, 32'h0000_1000);
    fetch_cycle(1, 0, 1'b0, 32'h0);
    fetch_cycle(3, 1, 1'b1, 32'h0000_0080);
    chk("wait_redirect_pc", fu.pc, 32'h0000_0080);
    for (int i = 0; i < 30; i++) begin
      automatic int lat = $urandom_range(1, 5);
      automatic int mode = $urandom_range(0, 3);
      automatic logic tk = 1'($urandom);
      automatic logic [31:0] tg = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      tg[1:0] = 2'b00;
`endif
      fetch_cycle(lat, mode, tk, tg);
      if (mode == 0) retire(tk, tg);
    end
    retire(1'b1, 32'h0000_0040);
    force_lat = 3;
    addr_q.push_back(m_pc[15:2]);
    fu.state = ST_FETCH;
    begin
      int n = 0;
      bit seen = 0;
      while (!seen && n < 20) begin
        @(posedge clk); #1;
        n++;
        seen = fu.imem_req;
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL req_timeout cycles=%0d limit=20", n);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    fu.state = ST_DECODE;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 32'h0;
    repeat (6) @(posedge clk);
    #1;
    chk("stale_instr", fu.instr_raw, NOP_INSTR);
    chk("stale_pc", fu.pc, 32'h0);
    fetch_cycle(1, 0, 1'b0, 32'h0);
    retire(1'b1, 32'h0000_0202);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_pc", fu.pc, 32'h0);
    chk("trap_err", 32'(fu.misalign_err), 32'd1);
    fu.state = ST_FETCH;
    repeat (10) @(posedge clk);
    #1 fu.state = ST_DECODE;
    chk("trap_err_sticky", 32'(fu.misalign_err), 32'd1);
    chk("trap_pc_held", fu.pc, 32'h0);
`else
    chk("force_align_pc", fu.pc, 32'h0000_0200);
    chk("force_align_err", 32'(fu.misalign_err), 32'd0);
    fetch_cycle(2, 0, 1'b0, 32'h0);
`endif
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expect fetches=%0d reqs=%0d want=0", exp_q.size(), addr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1);
  end
endmodule
